// File: rtl/fifo_syn_param.sv
// Parametrised single-clock FIFO with occupancy count, runtime almost-full/empty
// levels, synchronous flush and an optional first-word-fall-through read port.
// Optional feature macro: FIFO_FWFT_EN (defined = first-word-fall-through read port).
module fifo_syn_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wen,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ren,
  output logic [DATA_W-1:0] rdout,
  output logic              rvalid,
  input  logic [AW:0]       af_lvl,
  input  logic [AW:0]       ae_lvl,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          rd_acc, wr_acc;

`ifndef FIFO_FWFT_EN
  logic [DATA_W-1:0] rdout_q, rdout_d;
  logic              rvalid_q, rvalid_d;
`endif

  // Accept decisions; flush and reset block both sides.
  always_comb begin
    rd_acc = ren & ~empty_q & ~clr & ~rst;
    wr_acc = wen & (~full_q | rd_acc) & ~clr & ~rst;
  end

  // Next-state for pointers, occupancy, flags and (standard mode) read data.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    full_d  = full_q;
    empty_d = empty_q;
    af_d    = af_q;
    ae_d    = ae_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
`ifndef FIFO_FWFT_EN
    rdout_d  = rdout_q;
    rvalid_d = 1'b0;
`endif
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      full_d  = 1'b0;
      empty_d = 1'b1;
      af_d    = 1'b0;
      ae_d    = 1'b1;
`ifndef FIFO_FWFT_EN
      rdout_d = '0;
`endif
    end else begin
      if (wr_acc) wptr_d = wptr_q + AW'(1);
      if (rd_acc) rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
      af_d    = (count_d >= af_lvl);
      ae_d    = (count_d <= ae_lvl);
      ovf_d   = wen & ~wr_acc;
      unf_d   = ren & ~rd_acc;
`ifndef FIFO_FWFT_EN
      rvalid_d = rd_acc;
      if (rd_acc) rdout_d = mem[rptr_q];
`endif
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`ifndef FIFO_FWFT_EN
      rdout_q  <= '0;
      rvalid_q <= 1'b0;
`endif
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`ifndef FIFO_FWFT_EN
      rdout_q  <= rdout_d;
      rvalid_q <= rvalid_d;
`endif
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q] <= data_in;
  end

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

`ifdef FIFO_FWFT_EN
  // Head entry shown directly; zero while empty so reset/flush present 0.
  assign rdout  = empty_q ? '0 : mem[rptr_q];
  assign rvalid = ~empty_q;
`else
  assign rdout  = rdout_q;
  assign rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_fifo_syn_param.sv
// Directed plus scoreboard-checked random bench for fifo_syn_param (DEPTH=8).
module tb_fifo_syn_param;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AW     = 3;

  logic              clk = 1'b0;
  logic              rst, clr, wen, ren;
  logic [DATA_W-1:0] data_in, rdout;
  logic              rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]       af_lvl, ae_lvl, count;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_q[$];

  fifo_syn_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wen(wen), .data_in(data_in), .ren(ren),
    .rdout(rdout), .rvalid(rvalid), .af_lvl(af_lvl), .ae_lvl(ae_lvl),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given request inputs; returns 1 ns after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wen = w; data_in = d; ren = r;
    @(posedge clk); #1;
    wen = 1'b0; ren = 1'b0;
  endtask

  // Pop one word and check it against the expected value in either read mode.
  task automatic read_chk(input string tag, input logic [7:0] exp);
`ifdef FIFO_FWFT_EN
    chk({tag, "_rv"}, 32'(rvalid), 1);
    chk({tag, "_d"}, 32'(rdout), 32'(exp));
    step(1'b0, 8'h00, 1'b1);
`else
    step(1'b0, 8'h00, 1'b1);
    chk({tag, "_rv"}, 32'(rvalid), 1);
    chk({tag, "_d"}, 32'(rdout), 32'(exp));
`endif
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wen = 1'b0; ren = 1'b0; data_in = '0;
    af_lvl = 4'd6; ae_lvl = 4'd2;

    // 1. reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_rdout", 32'(rdout), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    rst = 1'b0;

    // 2. fill and overflow
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 8'(k), 1'b0);
      chk("fill_count", 32'(count), 32'(k));
      chk("fill_ae", 32'(almost_empty), (k <= 2) ? 1 : 0);
      chk("fill_af", 32'(almost_full), (k >= 6) ? 1 : 0);
      chk("fill_full", 32'(full), (k == 8) ? 1 : 0);
    end
    step(1'b1, 8'hFF, 1'b0);
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 8);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_clear", 32'(overflow), 0);

    // 3. drain and underflow
    for (int k = 1; k <= 8; k++) begin
      read_chk("drain", 8'(k));
      chk("drain_count", 32'(count), 32'(8 - k));
    end
    chk("drain_empty", 32'(empty), 1);
    step(1'b0, 8'h00, 1'b1);
    chk("unf_pulse", 32'(underflow), 1);
    chk("unf_rvalid", 32'(rvalid), 0);
`ifndef FIFO_FWFT_EN
    chk("unf_hold", 32'(rdout), 32'h08);
`endif
    step(1'b0, 8'h00, 1'b0);
    chk("unf_clear", 32'(underflow), 0);

    // 4. simultaneous read/write when full, then when empty
    for (int k = 1; k <= 8; k++) step(1'b1, 8'(k), 1'b0);
    chk("refill_full", 32'(full), 1);
    for (int k = 0; k < 4; k++) begin
`ifdef FIFO_FWFT_EN
      chk("fullrw_d", 32'(rdout), 32'(k + 1));
      step(1'b1, 8'(8'h10 + k), 1'b1);
`else
      step(1'b1, 8'(8'h10 + k), 1'b1);
      chk("fullrw_rv", 32'(rvalid), 1);
      chk("fullrw_d", 32'(rdout), 32'(k + 1));
`endif
      chk("fullrw_count", 32'(count), 8);
      chk("fullrw_ovf", 32'(overflow), 0);
    end
    for (int k = 5; k <= 8; k++) read_chk("rest", 8'(k));
    for (int k = 0; k < 4; k++) read_chk("rest_new", 8'(8'h10 + k));
    chk("rest_empty", 32'(empty), 1);
    step(1'b1, 8'h20, 1'b1);
    chk("emprw_unf", 32'(underflow), 1);
    chk("emprw_count", 32'(count), 1);
    chk("emprw_empty", 32'(empty), 0);
    read_chk("emprw_rd", 8'h20);

    // 5. random interleaving against a queue model
    for (int c = 0; c < 40; c++) begin
      logic w, r, racc, wacc;
      logic [7:0] d, head;
      w = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 9) < 5);
      d = 8'($urandom);
      racc = r && (model_q.size() != 0);
      wacc = w && ((model_q.size() != DEPTH) || racc);
      head = (model_q.size() != 0) ? model_q[0] : 8'h00;
`ifdef FIFO_FWFT_EN
      if (racc) chk("rnd_d", 32'(rdout), 32'(head));
`endif
      step(w, d, r);
      if (racc) void'(model_q.pop_front());
      if (wacc) model_q.push_back(d);
`ifndef FIFO_FWFT_EN
      chk("rnd_rv", 32'(rvalid), 32'(racc));
      if (racc) chk("rnd_d", 32'(rdout), 32'(head));
`endif
      chk("rnd_count", 32'(count), 32'(model_q.size()));
      chk("rnd_ovf", 32'(overflow), 32'(w && !wacc));
      chk("rnd_unf", 32'(underflow), 32'(r && !racc));
    end

    // 6. flush at count 5, then write/read through
    clr = 1'b1; step(1'b0, 8'h00, 1'b0); clr = 1'b0;
    model_q.delete();
    for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h30 + k), 1'b0);
    chk("pre_clr_count", 32'(count), 5);
    clr = 1'b1; step(1'b1, 8'h55, 1'b1); clr = 1'b0;
    chk("clr_count", 32'(count), 0);
    chk("clr_empty", 32'(empty), 1);
    chk("clr_ae", 32'(almost_empty), 1);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_rvalid", 32'(rvalid), 0);
    chk("clr_rdout", 32'(rdout), 0);
    step(1'b1, 8'hAA, 1'b0);
    chk("aa_count", 32'(count), 1);
`ifdef FIFO_FWFT_EN
    chk("aa_fwft_rv", 32'(rvalid), 1);
    chk("aa_fwft_d", 32'(rdout), 32'hAA);
`endif
    read_chk("aa_rd", 8'hAA);
    chk("aa_empty", 32'(empty), 1);

    // almost_full level edge cases on live thresholds
    af_lvl = 4'd0; step(1'b1, 8'h01, 1'b0);
    chk("af_zero", 32'(almost_full), 1);
    af_lvl = 4'd9; step(1'b0, 8'h00, 1'b1);
    chk("af_over", 32'(almost_full), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
